pipe_cu: RTL

//  Pipelined control unit for the 5-stage RV32I core. Decodes OPC/func3/func7 in ID and carries the control bundle

---
 rtl/pipe_cu_pkg.sv | 54 +++++
 rtl/pipe_cu_if.sv | 44 ++++
 rtl/pipe_cu_decode.sv | 88 ++++++++
 rtl/pipe_cu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipe_cu_pkg.sv
// pipe_cu_pkg: shared encodings for the pipelined RV32I control unit.
//   - opcode constants for every instruction class the decoder knows
//   - ALU / writeback-select / forward-select encodings
//   - ctrl_t: the control bundle carried from ID through WB
package pipe_cu_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] WB_DATAR = 2'd0;
    localparam logic [1:0] WB_ALU   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       asel;
        logic       bsel;
        logic [3:0] alusel;
        logic       brun;
        logic       memrw;
        logic       regwen;
        logic [1:0] wbsel;
        logic       jump;
        logic       branch;
        logic       is_load;
        logic       ecall;
        logic       illegal;
        logic [2:0] func3;
    } ctrl_t;

    // A bubble writes nothing; WBSel rests at ALU so idle outputs are 0 except wb_WBSel.
    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c       = '0;
        c.wbsel = WB_ALU;
        return c;
    endfunction

endpackage

// File: rtl/pipe_cu_if.sv
// pipe_cu_if: ID/EX-side inputs and per-stage control outputs of pipe_cu.
//   master: the datapath (drives ID fields and comparator results, reads controls)
//   slave:  pipe_cu
interface pipe_cu_if #(parameter int REG_AW = 5);
    logic              id_valid;
    logic [6:0]        OPC;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              BrEQ;
    logic              BrLT;
    logic              ex_ASel;
    logic              ex_BSel;
    logic [3:0]        ex_ALUSel;
    logic              ex_BrUn;
    logic              ex_PCSel;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic              mem_MemRW;
    logic [2:0]        mem_func3;
    logic              wb_RegWEn;
    logic [1:0]        wb_WBSel;
    logic [REG_AW-1:0] wb_rd;
    logic              stall;
    logic              flush;
    logic              illegal;
    logic              halt;

    modport master (
        output id_valid, OPC, func3, func7, rs1, rs2, rd, BrEQ, BrLT,
        input  ex_ASel, ex_BSel, ex_ALUSel, ex_BrUn, ex_PCSel, fwdA, fwdB,
               mem_MemRW, mem_func3, wb_RegWEn, wb_WBSel, wb_rd,
               stall, flush, illegal, halt
    );

    modport slave (
        input  id_valid, OPC, func3, func7, rs1, rs2, rd, BrEQ, BrLT,
        output ex_ASel, ex_BSel, ex_ALUSel, ex_BrUn, ex_PCSel, fwdA, fwdB,
               mem_MemRW, mem_func3, wb_RegWEn, wb_WBSel, wb_rd,
               stall, flush, illegal, halt
    );
endinterface

// File: rtl/pipe_cu_decode.sv
// pipe_cu_decode: combinational ID-stage decode table.
//   in:  id_valid, opc, func3, func7, rd_zero (rd == x0)
//   out: ctrl (control bundle for ID->EX), use_rs1/use_rs2 (sources actually read)
module pipe_cu_decode
    import pipe_cu_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] opc,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       rd_zero,
    output ctrl_t      ctrl,
    output logic       use_rs1,
    output logic       use_rs2
);

    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        ctrl    = ctrl_bubble();
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (id_valid) begin
            ctrl.valid = 1'b1;
            ctrl.func3 = func3;
            use_rs1    = (opc != OPC_LUI) && (opc != OPC_JAL);
            case (opc)
                OPC_R_TYPE: begin
                    ctrl.regwen = 1'b1;
                    ctrl.alusel = {func7[5], func3};
                    use_rs2     = 1'b1;
                end
                OPC_I_TYPE: begin
                    ctrl.bsel   = 1'b1;
                    ctrl.regwen = 1'b1;
                    // only SRAI uses func7[5]; for other immediates it is immediate data
                    ctrl.alusel = {(func3 == 3'b101) && func7[5], func3};
                end
                OPC_LOAD: begin
                    ctrl.bsel    = 1'b1;
                    ctrl.regwen  = 1'b1;
                    ctrl.wbsel   = WB_DATAR;
                    ctrl.is_load = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.bsel  = 1'b1;
                    ctrl.memrw = 1'b1;
                    use_rs2    = 1'b1;
                end
                OPC_B_TYPE: begin
                    ctrl.asel   = 1'b1;
                    ctrl.bsel   = 1'b1;
                    ctrl.brun   = func3[1];
                    ctrl.branch = 1'b1;
                    use_rs2     = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.asel   = 1'b1;
                    ctrl.bsel   = 1'b1;
                    ctrl.regwen = 1'b1;
                    ctrl.wbsel  = WB_PC4;
                    ctrl.jump   = 1'b1;
                end
                OPC_JALR: begin
                    ctrl.bsel   = 1'b1;
                    ctrl.regwen = 1'b1;
                    ctrl.wbsel  = WB_PC4;
                    ctrl.jump   = 1'b1;
                end
                OPC_LUI: begin
                    ctrl.bsel   = 1'b1;
                    ctrl.regwen = 1'b1;
                    ctrl.alusel = ALU_PASSB;
                end
                OPC_AUIPC: begin
                    ctrl.asel   = 1'b1;
                    ctrl.bsel   = 1'b1;
                    ctrl.regwen = 1'b1;
                end
                OPC_ECALL: ctrl.ecall   = 1'b1;
                default:   ctrl.illegal = 1'b1;
            endcase
            if (rd_zero) ctrl.regwen = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_cu.sv
// pipe_cu: pipelined control unit for the 5-stage RV32I core.
//   clock, reset : core clock, synchronous active-high reset
//   bus (slave)  : ID fields + BrEQ/BrLT in; per-stage controls, forward selects,
//                  stall/flush, illegal pulse and sticky halt out
//   ENABLE_FWD   : 1 forwarding + load-use stall; 0 no forwarding, stall on any RAW
module pipe_cu
    import pipe_cu_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter bit ENABLE_FWD = 1'b1
)
(
    input logic     clock,
    input logic     reset,
    pipe_cu_if.slave bus
);

    ctrl_t id_ctrl;
    logic  id_use_rs1, id_use_rs2;

    pipe_cu_decode u_decode (
        .id_valid (bus.id_valid),
        .opc      (bus.OPC),
        .func3    (bus.func3),
        .func7    (bus.func7),
        .rd_zero  (bus.rd == '0),
        .ctrl     (id_ctrl),
        .use_rs1  (id_use_rs1),
        .use_rs2  (id_use_rs2)
    );

    ctrl_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic              halt_q, halt_d;

    logic       br_taken, ex_pcsel, raw_hazard, halt, stall;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic id_reads(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] s1, input logic [REG_AW-1:0] s2,
                                      input logic u1, input logic u2);
        return (r != '0) && ((u1 && (s1 == r)) || (u2 && (s2 == r)));
    endfunction

    always_comb begin
        br_taken = 1'b0;
        case (ex_q.func3)
            3'b000:         br_taken = bus.BrEQ;
            3'b001:         br_taken = !bus.BrEQ;
            3'b100, 3'b110: br_taken = bus.BrLT;
            3'b101, 3'b111: br_taken = !bus.BrLT;
            default:        br_taken = 1'b0;
        endcase
        ex_pcsel = ex_q.valid && (ex_q.jump || (ex_q.branch && br_taken));
    end

    always_comb begin
        if (ENABLE_FWD) begin
            raw_hazard = ex_q.valid && ex_q.is_load &&
                         id_reads(ex_rd_q, bus.rs1, bus.rs2, id_use_rs1, id_use_rs2);
        end else begin
            raw_hazard = (ex_q.regwen  && id_reads(ex_rd_q,  bus.rs1, bus.rs2, id_use_rs1, id_use_rs2)) ||
                         (mem_q.regwen && id_reads(mem_rd_q, bus.rs1, bus.rs2, id_use_rs1, id_use_rs2)) ||
                         (wb_q.regwen  && id_reads(wb_rd_q,  bus.rs1, bus.rs2, id_use_rs1, id_use_rs2));
        end
        halt  = halt_q || (wb_q.valid && wb_q.ecall);
        // a taken redirect squashes the ID instruction, so holding it would be pointless
        stall = !ex_pcsel && (halt || raw_hazard);
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ENABLE_FWD) begin
            // a load in EX/MEM has no data yet; the load-use stall covers that case
            if (mem_q.regwen && !mem_q.is_load && (mem_rd_q == ex_rs1_q)) fwd_a = FWD_EXMEM;
            else if (wb_q.regwen && (wb_rd_q == ex_rs1_q))                fwd_a = FWD_MEMWB;
            if (mem_q.regwen && !mem_q.is_load && (mem_rd_q == ex_rs2_q)) fwd_b = FWD_EXMEM;
            else if (wb_q.regwen && (wb_rd_q == ex_rs2_q))                fwd_b = FWD_MEMWB;
        end
    end

    always_comb begin
        ex_d     = id_ctrl;
        ex_rd_d  = bus.rd;
        ex_rs1_d = bus.rs1;
        ex_rs2_d = bus.rs2;
        if (stall || ex_pcsel || !bus.id_valid) begin
            ex_d     = ctrl_bubble();
            ex_rd_d  = '0;
            ex_rs1_d = '0;
            ex_rs2_d = '0;
        end
        mem_d    = ex_q;
        mem_rd_d = ex_rd_q;
        wb_d     = mem_q;
        wb_rd_d  = mem_rd_q;
        halt_d   = halt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q     <= ctrl_bubble();
            mem_q    <= ctrl_bubble();
            wb_q     <= ctrl_bubble();
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
            halt_q   <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            ex_rd_q  <= ex_rd_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            mem_rd_q <= mem_rd_d;
            wb_rd_q  <= wb_rd_d;
            halt_q   <= halt_d;
        end
    end

    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign bus.ex_ASel   = ex_q.asel;
    assign bus.ex_BSel   = ex_q.bsel;
    assign bus.ex_ALUSel = ex_q.alusel;
    assign bus.ex_BrUn   = ex_q.brun;
    assign bus.ex_PCSel  = ex_pcsel;
    assign bus.fwdA      = fwd_a;
    assign bus.fwdB      = fwd_b;
    assign bus.mem_MemRW = mem_q.memrw;
    assign bus.mem_func3 = mem_q.func3;
    assign bus.wb_RegWEn = wb_q.regwen;
    assign bus.wb_WBSel  = wb_q.wbsel;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.stall     = stall;
    assign bus.flush     = ex_pcsel;
    assign bus.illegal   = ex_q.valid && ex_q.illegal;
    assign bus.halt      = halt;

endmodule
